fetch_stage: RTL and testbench

Instruction-fetch stage of the 32-bit MIPS pipeline. Holds the program counter, drives the byte address of the combinational, big-endian, 256-byte instruction memory, and registers the returned word with its PC+4 into the IF/ID pipeline register. Supports stall, flush and branch/jump redirect from downstream stages. A sticky fault state traps illegal fetch addresses.

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage and its surroundings: instruction memory,
// downstream control (stall/flush/redirect) and the IF/ID register outputs.
interface fetch_stage_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] pc;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic        fault;
   logic [31:0] fault_pc;

   modport master (
      output imem_addr, pc, ifid_instr, ifid_pc4, ifid_valid, fault, fault_pc,
      input  imem_data, stall, flush, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_addr, pc, ifid_instr, ifid_pc4, ifid_valid, fault, fault_pc,
      output imem_data, stall, flush, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register and a
// sticky fault trap for fetches outside the word-aligned instruction memory.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_BYTES = 256
) (
   input  logic           clk,
   input  logic           rst_n,
   fetch_stage_if.master  bus
);

   typedef enum logic {RUN, FAULT} state_t;

   localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic [31:0] fault_pc_q, fault_pc_d;
   logic [31:0] pc_plus4;

   // Unsigned compare also rejects targets that wrapped past 2^32.
   function automatic logic is_legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a <= LAST_ADDR);
   endfunction

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc4_d      = pc4_q;
      valid_d    = valid_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;

      case (state_q)
         RUN: begin
            if (bus.redirect_valid) begin
               instr_d = '0;
               pc4_d   = '0;
               valid_d = 1'b0;
               if (is_legal(bus.redirect_pc)) begin
                  pc_d = bus.redirect_pc;
               end else begin
                  fault_d    = 1'b1;
                  fault_pc_d = bus.redirect_pc;
                  state_d    = FAULT;
               end
            end else if (bus.flush) begin
               instr_d = '0;
               pc4_d   = '0;
               valid_d = 1'b0;
            end else if (!bus.stall) begin
               // The word at pc is delivered even when its successor is illegal.
               instr_d = bus.imem_data;
               pc4_d   = pc_plus4;
               valid_d = 1'b1;
               if (is_legal(pc_plus4)) begin
                  pc_d = pc_plus4;
               end else begin
                  fault_d    = 1'b1;
                  fault_pc_d = pc_plus4;
                  state_d    = FAULT;
               end
            end
         end
         FAULT: begin
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         pc4_q      <= '0;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc4_q      <= pc4_d;
         valid_q    <= valid_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   assign bus.imem_addr  = pc_q;
   assign bus.pc         = pc_q;
   assign bus.ifid_instr = instr_q;
   assign bus.ifid_pc4   = pc4_q;
   assign bus.ifid_valid = valid_q;
   assign bus.fault      = fault_q;
   assign bus.fault_pc   = fault_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed vectors push the hand-computed
// post-edge state; an independent monitor pops and compares after each edge.
module tb_fetch_stage;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        fault;
      logic [31:0] fault_pc;
   } exp_t;

   logic clk;
   logic rst_n;
   logic [7:0] mem [256];
   logic [7:0] byteAddr;
   exp_t expQ[$];
   int checks;
   int errors;

   fetch_stage_if bus ();

   fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .MEM_BYTES (256)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational big-endian instruction memory.
   assign byteAddr = bus.imem_addr[7:0];
   assign bus.imem_data = {mem[byteAddr], mem[byteAddr + 8'd1],
                           mem[byteAddr + 8'd2], mem[byteAddr + 8'd3]};

   task automatic setWord(input logic [7:0] addr, input logic [31:0] word);
      mem[addr]        = word[31:24];
      mem[addr + 8'd1] = word[23:16];
      mem[addr + 8'd2] = word[15:8];
      mem[addr + 8'd3] = word[7:0];
   endtask

   task automatic applyStimulus(
      input logic        rstN,
      input logic        stl,
      input logic        fls,
      input logic        rv,
      input logic [31:0] rpc,
      input logic [31:0] ePc,
      input logic [31:0] eInstr,
      input logic [31:0] ePc4,
      input logic        eValid,
      input logic        eFault,
      input logic [31:0] eFaultPc
   );
      exp_t e;
      @(negedge clk);
      rst_n              = rstN;
      bus.stall          = stl;
      bus.flush          = fls;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      e.pc       = ePc;
      e.instr    = eInstr;
      e.pc4      = ePc4;
      e.valid    = eValid;
      e.fault    = eFault;
      e.fault_pc = eFaultPc;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: one expectation per clock edge once the scoreboard is filling.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("pc",         bus.pc,                 e.pc);
            checkOutput("imem_addr",  bus.imem_addr,          e.pc);
            checkOutput("ifid_instr", bus.ifid_instr,         e.instr);
            checkOutput("ifid_pc4",   bus.ifid_pc4,           e.pc4);
            checkOutput("ifid_valid", {31'd0, bus.ifid_valid}, {31'd0, e.valid});
            checkOutput("fault",      {31'd0, bus.fault},      {31'd0, e.fault});
            checkOutput("fault_pc",   bus.fault_pc,           e.fault_pc);
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      setWord(8'h00, 32'h2008_0005);
      setWord(8'h04, 32'h2009_0007);
      setWord(8'h08, 32'h0109_5020);
      setWord(8'h0C, 32'h0000_0000);
      setWord(8'h40, 32'hAABB_CC40);
      setWord(8'hF8, 32'hDEAD_BEF8);
      setWord(8'hFC, 32'hCAFE_F0FC);

      rst_n              = 1'b0;
      bus.stall          = 1'b0;
      bus.flush          = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      repeat (2) @(posedge clk);

      //             rst  stl  fls  rv   rpc           pc            instr         pc4           v    f    fault_pc
      applyStimulus(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0,        1'b0,1'b0,32'h0);
      applyStimulus(1'b0,1'b0,1'b0,1'b1,32'h42,       32'h0,        32'h0,        32'h0,        1'b0,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b0,32'h0,        32'h4,        32'h2008_0005,32'h4,        1'b1,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b0,32'h0,        32'h8,        32'h2009_0007,32'h8,        1'b1,1'b0,32'h0);
      applyStimulus(1'b1,1'b1,1'b0,1'b0,32'h0,        32'h8,        32'h2009_0007,32'h8,        1'b1,1'b0,32'h0);
      applyStimulus(1'b1,1'b1,1'b0,1'b0,32'h0,        32'h8,        32'h2009_0007,32'h8,        1'b1,1'b0,32'h0);
      applyStimulus(1'b1,1'b1,1'b0,1'b0,32'h0,        32'h8,        32'h2009_0007,32'h8,        1'b1,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b0,32'h0,        32'hC,        32'h0109_5020,32'hC,        1'b1,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b1,32'h4,        32'h4,        32'h0,        32'h0,        1'b0,1'b0,32'h0);
      applyStimulus(1'b1,1'b1,1'b0,1'b1,32'h40,       32'h40,       32'h0,        32'h0,        1'b0,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b0,32'h0,        32'h44,       32'hAABB_CC40,32'h44,       1'b1,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b1,1'b1,32'h8,        32'h8,        32'h0,        32'h0,        1'b0,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b1,1'b0,32'h0,        32'h8,        32'h0,        32'h0,        1'b0,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b0,32'h0,        32'hC,        32'h0109_5020,32'hC,        1'b1,1'b0,32'h0);
      applyStimulus(1'b1,1'b1,1'b1,1'b0,32'h0,        32'hC,        32'h0,        32'h0,        1'b0,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b0,32'h0,        32'h10,       32'h0,        32'h10,       1'b1,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b1,32'hF8,       32'hF8,       32'h0,        32'h0,        1'b0,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b0,32'h0,        32'hFC,       32'hDEAD_BEF8,32'hFC,       1'b1,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b0,32'h0,        32'hFC,       32'hCAFE_F0FC,32'h100,      1'b1,1'b1,32'h100);
      applyStimulus(1'b1,1'b0,1'b0,1'b0,32'h0,        32'hFC,       32'h0,        32'h0,        1'b0,1'b1,32'h100);
      applyStimulus(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0,        1'b0,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b0,32'h0,        32'h4,        32'h2008_0005,32'h4,        1'b1,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b1,32'h42,       32'h4,        32'h0,        32'h0,        1'b0,1'b1,32'h42);
      applyStimulus(1'b1,1'b0,1'b0,1'b0,32'h0,        32'h4,        32'h0,        32'h0,        1'b0,1'b1,32'h42);
      applyStimulus(1'b1,1'b0,1'b0,1'b1,32'h0,        32'h4,        32'h0,        32'h0,        1'b0,1'b1,32'h42);
      applyStimulus(1'b1,1'b1,1'b1,1'b0,32'h0,        32'h4,        32'h0,        32'h0,        1'b0,1'b1,32'h42);
      applyStimulus(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0,        1'b0,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b0,32'h0,        32'h4,        32'h2008_0005,32'h4,        1'b1,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b1,32'hFFFF_FFFC,32'h4,        32'h0,        32'h0,        1'b0,1'b1,32'hFFFF_FFFC);
      applyStimulus(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0,        1'b0,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b1,32'h100,      32'h0,        32'h0,        32'h0,        1'b0,1'b1,32'h100);
      applyStimulus(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0,        1'b0,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b1,32'hFC,       32'hFC,       32'h0,        32'h0,        1'b0,1'b0,32'h0);
      applyStimulus(1'b1,1'b0,1'b0,1'b0,32'h0,        32'hFC,       32'hCAFE_F0FC,32'h100,      1'b1,1'b1,32'h100);

      // Let the monitor drain the scoreboard, with a bounded wait.
      begin
         int waitCycles;
         waitCycles = 0;
         while (expQ.size() > 0 && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
         end
         checks++;
         if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
